bram_bist_seq: RTL and testbench

//  Parametrised built-in self-test sequencer around an inferred simple dual-port block RAM.
//  On a start request it waits a programmable settle delay, then writes a selectable data pattern to every address.
//  It then reads every address back and compares each word against the regenerated pattern.

---
 rtl/bram_bist_seq.sv | 175 +++++++++++++++++
 tb/tb_bram_bist_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_bist_seq.sv
// Built-in self-test sequencer around an inferred simple dual-port block RAM.
// Writes a selectable pattern to every word, reads it back and reports pass/fail statistics.
module bram_bist_seq #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 11,
  parameter int DEPTH       = 2048,
  parameter int RD_LAT      = 1,
  parameter int START_DELAY = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              inject_err,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int DLY_W  = $clog2(START_DELAY + 1);
  localparam int MEM_AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] INJ_ADDR   = ADDR_W'(DEPTH / 2);
  localparam logic [DLY_W-1:0]  LAST_WAIT  = DLY_W'(START_DELAY - 1);
  localparam logic [DLY_W-1:0]  LAST_DRAIN = DLY_W'(RD_LAT - 1);

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] k);
    logic [DATA_W-1:0] kx;
    kx = DATA_W'(k);
    case (m)
      2'd0:    pattern = s + kx;
      2'd1:    pattern = s ^ kx;
      2'd2:    pattern = k[0] ? ~s : s;
      default: pattern = s;
    endcase
  endfunction

  state_t              state_r, state_next_s;
  logic [DLY_W-1:0]    dly_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [1:0]          mode_r;
  logic [DATA_W-1:0]   seed_r;
  logic                inj_r;
  logic                accept_s;
  logic [DATA_W-1:0]   exp_s, wdata_s;
  logic [DATA_W-1:0]   mem_r [0:(1<<MEM_AW)-1];
  logic [DATA_W-1:0]   rd_q1_r, rd_q2_r, ram_q_s;
  logic                vld_r   [2];
  logic [ADDR_W-1:0]   paddr_r [2];
  logic [DATA_W-1:0]   pexp_r  [2];
  logic                mismatch_s;
  logic [15:0]         err_next_s;

  assign accept_s = (state_r == ST_IDLE) && start;
  assign exp_s    = pattern(mode_r, seed_r, addr_r);
  assign wdata_s  = exp_s ^ {{(DATA_W-1){1'b0}}, (inj_r && (addr_r == INJ_ADDR))};
  assign ram_q_s  = (RD_LAT == 2) ? rd_q2_r : rd_q1_r;
  assign state    = state_r;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_next_s;
  end

  // Next-state logic driven by the delay and address counters
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  if (start) state_next_s = ST_WAIT;                 else state_next_s = ST_IDLE;
      ST_WAIT:  if (dly_r == LAST_WAIT) state_next_s = ST_WRITE;   else state_next_s = ST_WAIT;
      ST_WRITE: if (addr_r == LAST_ADDR) state_next_s = ST_READ;   else state_next_s = ST_WRITE;
      ST_READ:  if (addr_r == LAST_ADDR) state_next_s = ST_DRAIN;  else state_next_s = ST_READ;
      ST_DRAIN: if (dly_r == LAST_DRAIN) state_next_s = ST_DONE;   else state_next_s = ST_DRAIN;
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Delay counter for WAIT/DRAIN, address counter for WRITE/READ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_r  <= {DLY_W{1'b0}};
      addr_r <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        ST_WAIT, ST_DRAIN: begin
          dly_r  <= (state_next_s != state_r) ? {DLY_W{1'b0}} : dly_r + DLY_W'(1'b1);
          addr_r <= {ADDR_W{1'b0}};
        end
        ST_WRITE, ST_READ: begin
          dly_r  <= {DLY_W{1'b0}};
          addr_r <= (addr_r == LAST_ADDR) ? {ADDR_W{1'b0}} : addr_r + ADDR_W'(1'b1);
        end
        default: begin
          dly_r  <= {DLY_W{1'b0}};
          addr_r <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  // RAM array and output registers; contents intentionally not reset
  always_ff @(posedge clk) begin
    if (state_r == ST_WRITE) mem_r[addr_r[MEM_AW-1:0]] <= wdata_s;
    rd_q1_r <= mem_r[addr_r[MEM_AW-1:0]];
    rd_q2_r <= rd_q1_r;
  end

  // Compare pipeline carries address and expected word alongside the RAM read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r[0]   <= 1'b0;           vld_r[1]   <= 1'b0;
      paddr_r[0] <= {ADDR_W{1'b0}}; paddr_r[1] <= {ADDR_W{1'b0}};
      pexp_r[0]  <= {DATA_W{1'b0}}; pexp_r[1]  <= {DATA_W{1'b0}};
    end else begin
      vld_r[0]   <= (state_r == ST_READ); vld_r[1]   <= vld_r[0];
      paddr_r[0] <= addr_r;               paddr_r[1] <= paddr_r[0];
      pexp_r[0]  <= exp_s;                pexp_r[1]  <= pexp_r[0];
    end
  end

  assign mismatch_s = vld_r[RD_LAT-1] && (ram_q_s != pexp_r[RD_LAT-1]);

  // Saturating error counter increment
  always_comb begin
    err_next_s = err_count;
    if (mismatch_s && (err_count != 16'hFFFF)) err_next_s = err_count + 16'd1;
    else                                       err_next_s = err_count;
  end

  // Run configuration latch and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 16'd0;
      first_err_addr <= {ADDR_W{1'b0}};
      mode_r         <= 2'd0;
      seed_r         <= {DATA_W{1'b0}};
      inj_r          <= 1'b0;
    end else begin
      busy <= (state_next_s != ST_IDLE);
      done <= (state_next_s == ST_DONE);
      if (accept_s) begin
        mode_r         <= mode;
        seed_r         <= seed;
        inj_r          <= inject_err;
        err_count      <= 16'd0;
        first_err_addr <= {ADDR_W{1'b0}};
        pass           <= 1'b0;
      end else begin
        err_count <= err_next_s;
        if (mismatch_s && (err_count == 16'd0)) first_err_addr <= paddr_r[RD_LAT-1];
        if (state_next_s == ST_DONE) pass <= (err_next_s == 16'd0);
      end
    end
  end

endmodule

// File: tb/tb_bram_bist_seq.sv
// Self-checking bench for bram_bist_seq: a behavioural pattern/RAM model predicts every run.
module tb_bram_bist_seq;
  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, inject_err, start2, inject_err2;
  logic [1:0]  mode, mode2;
  logic [15:0] seed;
  logic [7:0]  seed2;
  logic        busy, done, pass, busy2, done2, pass2;
  logic [15:0] err_count, err_count2;
  logic [4:0]  first_err_addr, first_err_addr2;
  logic [2:0]  state, state2;

  int checks = 0;
  int errors = 0;
  logic [15:0] mmem [N];

  bram_bist_seq #(.DATA_W(16), .ADDR_W(5), .DEPTH(16), .RD_LAT(1), .START_DELAY(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .inject_err(inject_err),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .state(state));

  bram_bist_seq #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .RD_LAT(2), .START_DELAY(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2), .seed(seed2), .inject_err(inject_err2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .first_err_addr(first_err_addr2), .state(state2));

  function automatic logic [15:0] pat16(input int m, input logic [15:0] s, input int k);
    case (m)
      0:       return s + 16'(k);
      1:       return s ^ 16'(k);
      2:       return (k % 2 == 1) ? ~s : s;
      default: return s;
    endcase
  endfunction

  function automatic logic [7:0] pat8(input int m, input logic [7:0] s, input int k);
    case (m)
      0:       return s + 8'(k);
      1:       return s ^ 8'(k);
      2:       return (k % 2 == 1) ? ~s : s;
      default: return s;
    endcase
  endfunction

  // Model: RAM image after the write pass, then count read-back differences.
  task automatic model16(input int m, input logic [15:0] s, input bit inj,
                         output int e, output int f, output bit p);
    for (int k = 0; k < N; k++) mmem[k] = pat16(m, s, k) ^ ((inj && k == N/2) ? 16'h1 : 16'h0);
    e = 0; f = 0;
    for (int k = 0; k < N; k++)
      if (mmem[k] !== pat16(m, s, k)) begin
        if (e == 0) f = k;
        e++;
      end
    p = (e == 0);
  endtask

  // Launch one run on dut; returns the cycle (T+c) in which done was first seen, -1 on timeout.
  task automatic run1(input logic [1:0] m, input logic [15:0] s, input bit inj, input int poke,
                      input bit scramble, output int dcyc, output logic b1);
    @(posedge clk); #1;
    start = 1'b1; mode = m; seed = s; inject_err = inj;
    @(posedge clk); #1;
    start = 1'b0; dcyc = -1; b1 = busy;
    for (int c = 1; c <= 200; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (scramble && c == 3) begin
        mode = 2'($urandom); seed = 16'($urandom); inject_err = 1'($urandom);
      end
      start = (c == poke);
      if (done) begin dcyc = c; break; end
    end
    start = 1'b0;
  endtask

  task automatic run2(input logic [1:0] m, input logic [7:0] s, input bit inj, output int dcyc);
    @(posedge clk); #1;
    start2 = 1'b1; mode2 = m; seed2 = s; inject_err2 = inj;
    @(posedge clk); #1;
    start2 = 1'b0; dcyc = -1;
    for (int c = 1; c <= 200; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (done2) begin dcyc = c; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 2'd0; seed = 16'd0; inject_err = 1'b0;
    start2 = 1'b0; mode2 = 2'd0; seed2 = 8'd0; inject_err2 = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %0h exp 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %0h exp 0", done); end
    checks++; if (pass !== 1'b0)  begin errors++; $display("FAIL reset_pass: got %0h exp 0", pass); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err: got %0h exp 0", err_count); end
    checks++; if (first_err_addr !== 5'd0) begin errors++; $display("FAIL reset_first: got %0h exp 0", first_err_addr); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0h exp 0", state); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_incr();
    int d, e, f; bit p; logic b1;
    model16(0, 16'h0000, 1'b0, e, f, p);
    run1(2'd0, 16'h0000, 1'b0, 0, 1'b0, d, b1);
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL incr_busy: got %0h exp 1", b1); end
    checks++; if (d != 38) begin errors++; $display("FAIL incr_done_cycle: got %0d exp 38", d); end
    checks++; if (pass !== p) begin errors++; $display("FAIL incr_pass: got %0h exp %0h", pass, p); end
    checks++; if (err_count !== 16'(e)) begin errors++; $display("FAIL incr_err: got %0d exp %0d", err_count, e); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL incr_after_done: got done=%0h busy=%0h exp 0 0", done, busy); end
  endtask

  task automatic test_inject();
    int d, e, f; bit p; logic b1;
    model16(1, 16'h5A5A, 1'b1, e, f, p);
    run1(2'd1, 16'h5A5A, 1'b1, 0, 1'b0, d, b1);
    checks++; if (pass !== p) begin errors++; $display("FAIL inj_pass: got %0h exp %0h", pass, p); end
    checks++; if (err_count !== 16'(e)) begin errors++; $display("FAIL inj_err: got %0d exp %0d", err_count, e); end
    checks++; if (first_err_addr !== 5'(f)) begin errors++; $display("FAIL inj_first: got %0d exp %0d", first_err_addr, f); end
    model16(1, 16'h5A5A, 1'b0, e, f, p);
    run1(2'd1, 16'h5A5A, 1'b0, 0, 1'b0, d, b1);
    checks++; if (pass !== p || err_count !== 16'(e) || first_err_addr !== 5'(f))
      begin errors++; $display("FAIL inj_rerun: got pass=%0h err=%0d first=%0d exp %0h %0d %0d", pass, err_count, first_err_addr, p, e, f); end
  endtask

  task automatic test_checker();
    int d, e, f; bit p; logic b1;
    model16(2, 16'h00FF, 1'b0, e, f, p);
    run1(2'd2, 16'h00FF, 1'b0, 0, 1'b0, d, b1);
    checks++; if (dut.mem_r[3] !== pat16(2, 16'h00FF, 3)) begin errors++; $display("FAIL chk_addr3: got %0h exp %0h", dut.mem_r[3], pat16(2, 16'h00FF, 3)); end
    checks++; if (dut.mem_r[4] !== pat16(2, 16'h00FF, 4)) begin errors++; $display("FAIL chk_addr4: got %0h exp %0h", dut.mem_r[4], pat16(2, 16'h00FF, 4)); end
    checks++; if (pass !== p) begin errors++; $display("FAIL chk_pass: got %0h exp %0h", pass, p); end
  endtask

  task automatic test_random();
    int d, e, f, bad; bit p, inj; logic b1; logic [1:0] m; logic [15:0] s;
    for (int i = 0; i < 6; i++) begin
      m = 2'($urandom); s = 16'($urandom); inj = 1'($urandom);
      model16(int'(m), s, inj, e, f, p);
      run1(m, s, inj, 0, 1'b1, d, b1);
      checks++; if (d != 38) begin errors++; $display("FAIL rnd%0d_done_cycle: got %0d exp 38", i, d); end
      checks++; if (pass !== p || err_count !== 16'(e) || first_err_addr !== 5'(f))
        begin errors++; $display("FAIL rnd%0d_status: got pass=%0h err=%0d first=%0d exp %0h %0d %0d", i, pass, err_count, first_err_addr, p, e, f); end
      bad = 0;
      for (int k = 0; k < N; k++) if (dut.mem_r[k] !== mmem[k]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rnd%0d_ram_image: got %0d bad words exp 0", i, bad); end
    end
  endtask

  task automatic test_ignored_start();
    int d, extra; logic b1;
    run1(2'd0, 16'h1234, 1'b0, 10, 1'b0, d, b1);
    checks++; if (d != 38) begin errors++; $display("FAIL ign_done_cycle: got %0d exp 38", d); end
    extra = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ign_no_rerun: got %0d active cycles exp 0", extra); end
    run1(2'd3, 16'hBEEF, 1'b0, 0, 1'b0, d, b1);
    checks++; if (d != 38 || pass !== 1'b1) begin errors++; $display("FAIL ign_next_run: got cyc=%0d pass=%0h exp 38 1", d, pass); end
  endtask

  task automatic test_back_to_back();
    int d1, d2; logic b39;
    d1 = -1; d2 = -1; b39 = 1'bx;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd3; seed = 16'($urandom);
    @(posedge clk); #1;
    for (int c = 1; c <= 120; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 39) b39 = busy;
      if (done && d1 < 0) d1 = c;
      else if (done) begin d2 = c; start = 1'b0; break; end
    end
    start = 1'b0;
    checks++; if (d1 != 38) begin errors++; $display("FAIL b2b_first_done: got %0d exp 38", d1); end
    checks++; if (b39 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%0h exp 0", b39); end
    checks++; if (d2 != 77 || pass !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got cyc=%0d pass=%0h exp 77 1", d2, pass); end
  endtask

  task automatic test_reset_mid_write();
    int d; logic b1; logic [2:0] st;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd1; seed = 16'h0F0F;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    st = state;
    checks++; if (st !== 3'd2) begin errors++; $display("FAIL rst_mid_in_write: got state %0d exp 2", st); end
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== 16'd0 || first_err_addr !== 5'd0 || state !== 3'd0)
      begin errors++; $display("FAIL rst_mid_outputs: got busy=%0h done=%0h pass=%0h err=%0d first=%0d state=%0d exp all 0", busy, done, pass, err_count, first_err_addr, state); end
    @(negedge clk); rst = 1'b1;
    run1(2'd0, 16'($urandom), 1'b0, 0, 1'b0, d, b1);
    checks++; if (d != 38 || pass !== 1'b1) begin errors++; $display("FAIL rst_mid_rerun: got cyc=%0d pass=%0h exp 38 1", d, pass); end
  endtask

  task automatic test_rdlat2();
    int d;
    run2(2'd0, 8'hF8, 1'b0, d);
    checks++; if (d != 39) begin errors++; $display("FAIL lat2_done_cycle: got %0d exp 39", d); end
    checks++; if (pass2 !== 1'b1 || err_count2 !== 16'd0) begin errors++; $display("FAIL lat2_pass: got pass=%0h err=%0d exp 1 0", pass2, err_count2); end
    checks++; if (dut2.mem_r[15] !== pat8(0, 8'hF8, 15)) begin errors++; $display("FAIL lat2_wrap: got %0h exp %0h", dut2.mem_r[15], pat8(0, 8'hF8, 15)); end
    run2(2'd2, 8'h3C, 1'b1, d);
    checks++; if (pass2 !== 1'b0 || err_count2 !== 16'd1 || first_err_addr2 !== 5'(N/2))
      begin errors++; $display("FAIL lat2_inject: got pass=%0h err=%0d first=%0d exp 0 1 %0d", pass2, err_count2, first_err_addr2, N/2); end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_inject();
    test_checker();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_write();
    test_rdlat2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1);
  end
endmodule
